mage_in_stream_router: RTL

- Parametrised input-stream router between the DMA channels and the PEA data inputs of Mage.
- Each of N_STREAM streams groups CH_PER_STREAM DMA channels and DIN_PER_STREAM PEA inputs.
- Each PEA input selects its source channel at run time and has its own FWFT FIFO. One channel may broadcast to several PEA inputs.
- A per-stream length counter and FSM run a fixed-size transfer, drain the FIFOs, then signal done.

---
 rtl/mage_in_stream_router.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/mage_in_stream_router.sv
// mage_in_stream_router: DMA-channel to PEA-input router, per-input FWFT FIFOs.
// Define MAGE_IN_STREAM_PERF_EN to add per-stream stall counters (stall_cnt_o).
module mage_in_stream_router #(
  parameter int N_STREAM       = 2,
  parameter int CH_PER_STREAM  = 2,
  parameter int DIN_PER_STREAM = 2,
  parameter int DATA_W         = 32,
  parameter int FIFO_DEPTH     = 4,
  parameter int LEN_W          = 16,
  parameter int SEL_W          =
    (CH_PER_STREAM == 1) ? 1 : $clog2(CH_PER_STREAM)
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic [N_STREAM*CH_PER_STREAM*DATA_W-1:0] dma_data_i,
  input  logic [N_STREAM*CH_PER_STREAM-1:0] dma_valid_i,
  output logic [N_STREAM*CH_PER_STREAM-1:0] dma_ready_o,
  output logic [N_STREAM*DIN_PER_STREAM*DATA_W-1:0] pea_data_o,
  output logic [N_STREAM*DIN_PER_STREAM-1:0] pea_valid_o,
  input  logic [N_STREAM*DIN_PER_STREAM-1:0] pea_ready_i,
  input  logic [N_STREAM*DIN_PER_STREAM*SEL_W-1:0] cfg_sel_i,
  input  logic [N_STREAM*DIN_PER_STREAM-1:0] cfg_en_i,
  input  logic [N_STREAM*LEN_W-1:0] cfg_len_i,
  input  logic [N_STREAM-1:0] cfg_start_i,
  output logic [N_STREAM-1:0] busy_o,
  output logic [N_STREAM-1:0] done_o
`ifdef MAGE_IN_STREAM_PERF_EN
  ,
  output logic [N_STREAM*LEN_W-1:0] stall_cnt_o
`endif
);

  localparam int CH    = CH_PER_STREAM;
  localparam int DIN   = DIN_PER_STREAM;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  for (genvar s = 0; s < N_STREAM; s++) begin : g_st
    logic [1:0] state_q;
    logic done_q;
    logic [DIN-1:0] en_q;
    logic [SEL_W-1:0] sel_q [DIN];
    logic [LEN_W-1:0] rem_q [DIN];
    logic [DIN-1:0] act;
    logic [DIN-1:0] want;
    logic [DIN-1:0] push;
    logic [DIN-1:0] empty;
    logic [DIN-1:0] full;
    logic [DIN-1:0] cfg_ok;
    logic [CH-1:0] has_c;
    logic [CH-1:0] blk_c;
    logic [CH-1:0] rdy;
    logic [CH-1:0] hs;
    logic [DATA_W-1:0] din [DIN];
    logic [LEN_W-1:0] cfg_len;
    logic start;
    logic go;

    assign cfg_len = cfg_len_i[s*LEN_W +: LEN_W];
    assign start = cfg_start_i[s] && (state_q == S_IDLE);
    assign go = start && (|cfg_ok) && (cfg_len != '0);

    // Out-of-range selects fold into the enable here.
    always_comb begin
      for (int d = 0; d < DIN; d++) begin
        cfg_ok[d] = cfg_en_i[s*DIN+d] &&
          (32'(cfg_sel_i[(s*DIN+d)*SEL_W +: SEL_W]) < CH);
      end
    end

    always_comb begin
      for (int d = 0; d < DIN; d++) begin
        act[d] = en_q[d] && (rem_q[d] != '0);
        want[d] = act[d] && !full[d] && (state_q == S_RUN);
      end
    end

    always_comb begin
      has_c = '0;
      blk_c = '0;
      for (int d = 0; d < DIN; d++) begin
        for (int c = 0; c < CH; c++) begin
          if (act[d] && (32'(sel_q[d]) == c)) begin
            has_c[c] = 1'b1;
            if (!want[d]) blk_c[c] = 1'b1;
          end
        end
      end
    end

    assign rdy = has_c & ~blk_c;
    assign hs = rdy & dma_valid_i[s*CH +: CH];

    always_comb begin
      push = '0;
      for (int d = 0; d < DIN; d++) begin
        din[d] = '0;
        for (int c = 0; c < CH; c++) begin
          if (32'(sel_q[d]) == c) begin
            din[d] = dma_data_i[(s*CH+c)*DATA_W +: DATA_W];
            push[d] = act[d] && hs[c];
          end
        end
      end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        state_q <= S_IDLE;
        done_q <= 1'b0;
        en_q <= '0;
        for (int d = 0; d < DIN; d++) begin
          sel_q[d] <= '0;
          rem_q[d] <= '0;
        end
      end else begin
        done_q <= 1'b0;
        unique case (state_q)
          S_IDLE: begin
            if (cfg_start_i[s]) begin
              en_q <= cfg_ok;
              for (int d = 0; d < DIN; d++) begin
                sel_q[d] <= cfg_sel_i[(s*DIN+d)*SEL_W +: SEL_W];
              end
              if (go) state_q <= S_RUN;
              else done_q <= 1'b1;
            end
          end
          S_RUN: if (act == '0) state_q <= S_DRAIN;
          S_DRAIN: begin
            if (&empty) begin
              state_q <= S_IDLE;
              done_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
        for (int d = 0; d < DIN; d++) begin
          if (go) rem_q[d] <= cfg_ok[d] ? cfg_len : '0;
          else if (push[d]) rem_q[d] <= rem_q[d] - 1'b1;
        end
      end
    end

    for (genvar d = 0; d < DIN; d++) begin : g_in
      localparam int IDX = s*DIN + d;
      logic [DATA_W-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0] wp_q;
      logic [PTR_W-1:0] rp_q;
      logic [CNT_W-1:0] cnt_q;
      logic pop;

      assign empty[d] = (cnt_q == '0);
      assign full[d] = (cnt_q == CNT_W'(FIFO_DEPTH));
      assign pop = !empty[d] && pea_ready_i[IDX];

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          wp_q <= '0;
          rp_q <= '0;
          cnt_q <= '0;
        end else begin
          if (push[d]) wp_q <= wp_q + 1'b1;
          if (pop) rp_q <= rp_q + 1'b1;
          if (push[d] && !pop) cnt_q <= cnt_q + 1'b1;
          else if (!push[d] && pop) cnt_q <= cnt_q - 1'b1;
        end
      end

      always_ff @(posedge clk_i) begin
        if (push[d]) mem[wp_q] <= din[d];
      end

      assign pea_valid_o[IDX] = !empty[d];
      assign pea_data_o[IDX*DATA_W +: DATA_W] =
        empty[d] ? '0 : mem[rp_q];
    end

    assign dma_ready_o[s*CH +: CH] = rdy;
    assign busy_o[s] = (state_q != S_IDLE);
    assign done_o[s] = done_q;

`ifdef MAGE_IN_STREAM_PERF_EN
    logic [LEN_W-1:0] stall_q;
    logic stall;

    assign stall = (state_q == S_RUN) &&
      (|(has_c & ~rdy & dma_valid_i[s*CH +: CH]));

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) stall_q <= '0;
      else if (start) stall_q <= '0;
      else if (stall && (stall_q != '1)) stall_q <= stall_q + 1'b1;
    end

    assign stall_cnt_o[s*LEN_W +: LEN_W] = stall_q;
`endif
  end

endmodule
